// File: rtl/flash_bus_sequencer_pkg.sv
// rtl/flash_bus_sequencer_pkg.sv - shared types and widths for the flash bus sequencer
package flash_bus_sequencer_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef enum logic {WRITE, READ} grant_t;
endpackage

// File: rtl/flash_bus_sequencer_arbiter.sv
// rtl/flash_bus_sequencer_arbiter.sv - two-requester round-robin arbiter
module bus_arbiter_rr
  import flash_bus_sequencer_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_wr,
  input  logic req_rd,
  input  logic enable,
  input  logic update,
  output logic gnt_wr,
  output logic gnt_rd
);

  grant_t last_grant;

  // On a tie, the requester that did not win last time is favoured.
  always_comb begin
    gnt_wr = enable & req_wr & (~req_rd | (last_grant == READ));
    gnt_rd = enable & req_rd & (~req_wr | (last_grant == WRITE));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= READ;
    end else if (update) begin
      last_grant <= gnt_wr ? WRITE : READ;
    end
  end

endmodule

// File: rtl/flash_bus_sequencer.sv
// rtl/flash_bus_sequencer.sv - parallel flash bus sequencer with streaming write and random read ports
module flash_bus_sequencer
  import flash_bus_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 22'd200,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_out,
  input  logic [DATA_W-1:0] mem_dq_in,
  output logic              mem_dq_oe,
  output logic              mem_ce_n,
  output logic              mem_we_n,
  output logic              mem_oe_n
);

  localparam int CNT_W = 8;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  grant_t            op;
  logic [ADDR_W-1:0] wr_addr;
  logic              start_pend, apply_start;
  logic              gnt_wr, gnt_rd, accept, read_capture;

  // A pending start takes the whole IDLE cycle, so no grant competes with the address reset.
  assign apply_start  = (state == IDLE) && start_pend;
  assign read_capture = (state == STROBE) && (cnt == '0) && (op == READ);

  bus_arbiter_rr u_arbiter (
    .clock  (clock),
    .reset  (reset),
    .req_wr (wr_valid & ~done),
    .req_rd (rd_valid),
    .enable ((state == IDLE) && !start_pend),
    .update (accept),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  // Strobes decode straight from the state register so reset releases the bus at once.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_ready  = gnt_wr;
    rd_ready  = gnt_rd;
    accept    = gnt_wr | gnt_rd;
    busy      = (state != IDLE);
    mem_ce_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SETUP;
          cnt_nx   = CNT_W'(T_SETUP - 1);
        end
      end
      SETUP: begin
        mem_ce_n  = 1'b0;
        mem_dq_oe = (op == WRITE);
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = CNT_W'(T_PULSE - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      STROBE: begin
        mem_ce_n  = 1'b0;
        mem_we_n  = (op != WRITE);
        mem_oe_n  = (op != READ);
        mem_dq_oe = (op == WRITE);
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_nx   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HOLD: begin
        mem_ce_n  = 1'b0;
        mem_dq_oe = (op == WRITE);
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op            <= WRITE;
      wr_addr       <= '0;
      start_pend    <= 1'b0;
      done          <= 1'b0;
      mem_addr      <= '0;
      mem_dq_out    <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      rd_data_valid <= read_capture;
      if (read_capture) rd_data <= mem_dq_in;
      if (start) begin
        start_pend <= 1'b1;
      end else if (apply_start) begin
        start_pend <= 1'b0;
      end
      if (apply_start) begin
        wr_addr <= '0;
        done    <= 1'b0;
      end
      if (gnt_wr) begin
        op         <= WRITE;
        mem_addr   <= wr_addr;
        mem_dq_out <= wr_data;
        wr_addr    <= wr_addr + 1'b1;
        if (wr_addr + 1'b1 == FRAME_BYTES) done <= 1'b1;
      end else if (gnt_rd) begin
        op       <= READ;
        mem_addr <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_flash_bus_sequencer.sv
// tb/tb_flash_bus_sequencer.sv - scoreboard bench for flash_bus_sequencer
module tb_flash_bus_sequencer;

  logic        clock, reset, start;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0]  wr_data, rd_data, mem_dq_out, mem_dq_in;
  logic [21:0] rd_addr, mem_addr;
  logic        rd_data_valid, done, busy, mem_dq_oe, mem_ce_n, mem_we_n, mem_oe_n;

  typedef struct {
    bit          is_rd;
    logic [21:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];
  bit   glog[$];
  int   acyc[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, wr_count = 0, wr_base = 0, rdv_total = 0;
  int   ce_run = 0, we_run = 0, oe_run = 0;
  bit   rdv_prev = 0, saw_wr_acc = 0, saw_rd_acc = 0;

  flash_bus_sequencer #(.FRAME_BYTES(22'd4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_dq_out(mem_dq_out), .mem_dq_in(mem_dq_in),
    .mem_dq_oe(mem_dq_oe), .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n)
  );

  function automatic logic [7:0] flash_byte(input logic [21:0] a);
    return a[7:0] ^ 8'hF1;
  endfunction

  // Flash model drives data only while its outputs are enabled.
  assign mem_dq_in = mem_oe_n ? 8'h00 : flash_byte(mem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (q.size() == 0) begin
      check("q_nonempty", 0, 1);
      e = '{0, 22'h0, 8'h00};
    end else begin
      e = q.pop_front();
    end
  endtask

  task automatic observe();
    exp_t e;
    cyc++;
    saw_wr_acc = 0;
    saw_rd_acc = 0;
    if (reset) begin
      q.delete();
      ce_run = 0; we_run = 0; oe_run = 0; rdv_prev = 0;
      return;
    end
    if (wr_ready && rd_ready) check("one_ready", 1, 0);
    if (wr_valid && wr_ready) begin
      q.push_back('{0, 22'(wr_count - wr_base), wr_data});
      wr_count++; saw_wr_acc = 1; glog.push_back(0); acyc.push_back(cyc);
    end
    if (rd_valid && rd_ready) begin
      q.push_back('{1, rd_addr, flash_byte(rd_addr)});
      saw_rd_acc = 1; glog.push_back(1); acyc.push_back(cyc);
    end
    if (!mem_ce_n) ce_run++;
    else begin
      if (ce_run != 0) check("ce_len", ce_run, 6);
      ce_run = 0;
    end
    if (!mem_we_n) begin
      we_run++;
      if (we_run == 1) begin
        pop_exp(e);
        check("wr_setup", ce_run - 1, 2);
        check("wr_kind", e.is_rd, 0);
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_dq_out, e.data);
        check("wr_dq_oe", mem_dq_oe, 1);
      end
    end else begin
      if (we_run != 0) check("we_len", we_run, 3);
      we_run = 0;
    end
    if (!mem_oe_n) begin
      oe_run++;
      if (oe_run == 1) begin
        check("rd_setup", ce_run - 1, 2);
        check("rd_strobe_dq_oe", mem_dq_oe, 0);
      end
    end else begin
      if (oe_run != 0) check("oe_len", oe_run, 3);
      oe_run = 0;
    end
    if (rd_data_valid) begin
      rdv_total++;
      pop_exp(e);
      check("rdv_pulse", rdv_prev, 0);
      check("rd_kind", e.is_rd, 1);
      check("rd_addr", mem_addr, e.addr);
      check("rd_data", rd_data, e.data);
      check("rd_hold_bus", {mem_ce_n, mem_oe_n, mem_dq_oe}, 3'b010);
    end
    rdv_prev = rd_data_valid;
  endtask

  task automatic sample();
    @(negedge clock);
    observe();
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  function automatic bit ev(input int k);
    case (k)
      0:       return saw_wr_acc;
      1:       return saw_rd_acc;
      2:       return !busy;
      3:       return rd_data_valid;
      4:       return !mem_we_n;
      default: return !mem_oe_n;
    endcase
  endfunction

  // Leaves the bench at the negedge where the event was observed.
  task automatic wait_event(input int k, input int budget, output int n);
    n = 0;
    sample();
    while (!ev(k) && n < budget) begin
      advance();
      sample();
      n++;
    end
    if (!ev(k)) check($sformatf("timeout_ev%0d", k), 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, a0, r0, g0, nacc, nrdy, nogrant;
    bit wa, ra, last;
    reset = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_data = 8'h00; rd_addr = 22'h0;

    sample();
    check("rst_strobes", {mem_ce_n, mem_we_n, mem_oe_n}, 3'b111);
    check("rst_dq_oe", mem_dq_oe, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_dq_out", mem_dq_out, 0);
    check("rst_rd", {rd_data, rd_data_valid}, 0);
    check("rst_done_busy", {done, busy}, 0);
    advance();
    reset = 1'b0;

    // single write
    wr_valid = 1'b1; wr_data = 8'hA5;
    wait_event(0, 4, n);
    check("wr_acc_lat", n, 0);
    advance();
    wr_valid = 1'b0;
    wait_event(2, 20, n);
    check("idle_addr", mem_addr, 0);
    check("idle_dq_out", mem_dq_out, 8'hA5);
    check("idle_ce_dq_oe", {mem_ce_n, mem_dq_oe}, 2'b10);
    advance();

    // single read
    rd_valid = 1'b1; rd_addr = 22'h00ABCD;
    wait_event(1, 4, n);
    advance();
    rd_valid = 1'b0;
    r0 = rdv_total;
    wait_event(3, 20, n);
    check("rd_served", rdv_total, r0 + 1);
    check("rd_data_3c", rd_data, 8'h3C);
    advance();
    wait_event(2, 20, n);
    advance();

    // start during the STROBE of a write
    wr_valid = 1'b1; wr_data = 8'hB7;
    wait_event(0, 4, n);
    a0 = cyc;
    advance();
    wr_data = 8'hC8;
    wait_event(4, 10, n);
    advance();
    pulse_start();
    wr_base = wr_count;
    nogrant = 0; n = 0;
    sample();
    while (!saw_wr_acc && n < 20) begin
      if (!busy && !wr_ready) nogrant++;
      advance(); sample(); n++;
    end
    check("start_acc_gap", cyc - a0, 8);
    check("start_nogrant", nogrant, 1);
    check("start_done", done, 0);
    advance();
    wr_valid = 1'b0;
    wait_event(2, 20, n);
    advance();

    // both requesters held high: grants alternate
    pulse_start();
    tick();
    wr_base = wr_count;
    wr_valid = 1'b1; rd_valid = 1'b1; rd_addr = 22'h000100; wr_data = 8'h10;
    g0 = glog.size(); last = glog[g0-1]; n = 0;
    while (glog.size() - g0 < 6 && n < 80) begin
      sample(); wa = saw_wr_acc; ra = saw_rd_acc;
      advance(); n++;
      if (wa) wr_data = wr_data + 8'h1;
      if (ra) rd_addr = rd_addr + 22'h11;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("alt_count", glog.size() - g0, 6);
    for (int i = 0; i < 6 && g0 + i < glog.size(); i++) begin
      check("alt_kind", glog[g0+i], (i % 2 == 0) ? !last : last);
      if (i > 0) check("alt_gap", acyc[g0+i] - acyc[g0+i-1], 7);
    end
    wait_event(2, 20, n);
    check("alt_done", done, 0);
    advance();

    // frame completion with FRAME_BYTES = 4
    pulse_start();
    tick();
    wr_base = wr_count;
    wr_valid = 1'b1; wr_data = 8'hD0; nacc = 0; n = 0;
    while (nacc < 4 && n < 60) begin
      sample(); wa = saw_wr_acc;
      if (wa) begin
        nacc++;
        if (nacc == 4) check("done_pre", done, 0);
      end
      advance(); n++;
      if (wa) wr_data = wr_data + 8'h1;
    end
    check("done_acc4", nacc, 4);
    sample();
    check("done_set", done, 1);
    advance();
    nrdy = 0;
    repeat (30) begin
      sample();
      if (wr_ready) nrdy++;
      advance();
    end
    check("done_no_wr", nrdy, 0);
    rd_valid = 1'b1; rd_addr = 22'h3FFFFF;
    wait_event(1, 4, n);
    advance();
    rd_valid = 1'b0;
    r0 = rdv_total;
    wait_event(3, 20, n);
    check("done_rd_served", rdv_total, r0 + 1);
    advance();
    wait_event(2, 20, n);
    advance();
    pulse_start();
    sample();
    check("apply_done_held", done, 1);
    check("apply_no_grant", wr_ready, 0);
    advance();
    wr_base = wr_count;
    sample();
    check("start_cleared", done, 0);
    check("post_start_ready", wr_ready, 1);
    advance();
    wr_data = wr_data + 8'h1;
    wait_event(0, 12, n);
    advance();
    wr_valid = 1'b0;
    wait_event(2, 20, n);
    advance();

    // reset during the STROBE of a read
    rd_valid = 1'b1; rd_addr = 22'h000055;
    wait_event(1, 4, n);
    advance();
    rd_valid = 1'b0;
    wait_event(5, 10, n);
    advance();
    #2 reset = 1'b1;
    #1;
    check("abort_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    check("abort_busy_rdv", {busy, rd_data_valid}, 0);
    r0 = rdv_total;
    sample();
    advance();
    reset = 1'b0;
    wr_base = wr_count;
    repeat (10) tick();
    check("abort_no_rdv", rdv_total, r0);
    wr_valid = 1'b1; wr_data = 8'h11;
    wait_event(0, 4, n);
    check("post_rst_lat", n, 0);
    advance();
    wr_valid = 1'b0;
    wait_event(2, 20, n);
    advance();
    tick();
    check("q_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
